// File: rtl/sd_sec_wr_buf.sv
// sd_sec_wr_buf: ping-pong 16-bit sector buffer feeding the SD controller user write port.
// Define SEC_BUF_PAD_EN to let a flush pulse zero-pad and launch a partially filled sector.
module sd_sec_wr_buf #(
    parameter int          SEC_WORDS  = 256,
    parameter logic [31:0] START_ADDR = 32'd2000,
    parameter logic [15:0] BUSY_TO    = 16'd1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sd_init_done,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic        flush,
    input  logic        wr_busy,
    input  logic        wr_req,
    output logic        wr_start_en,
    output logic [31:0] wr_sec_addr,
    output logic [15:0] wr_data,
    output logic [31:0] sec_cnt,
    output logic        error_flag
);
    localparam int            AW       = $clog2(SEC_WORDS);
    localparam logic [AW-1:0] LAST     = AW'(SEC_WORDS - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(SEC_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_XFER,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic [15:0]   mem [2][SEC_WORDS];
    logic [1:0]    bank_full;
    logic          fill_sel;
    logic          drain_sel;
    logic [AW-1:0] wptr;
    logic [AW:0]   rptr;
    logic [15:0]   timer;
    logic          ready_en;
    logic          padding;
    logic          wr_en;
    logic [15:0]   wr_word;
    logic          timeout;

`ifdef SEC_BUF_PAD_EN
    // A flush that coincides with the last real word would leave wptr at 0, so it is dropped.
    logic pad_start;
    assign pad_start = flush && !padding && (wptr != '0)
                       && !(in_valid && in_ready && (wptr == LAST));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            padding <= 1'b0;
        end else if (pad_start) begin
            padding <= 1'b1;
        end else if (padding && (wptr == LAST)) begin
            padding <= 1'b0;
        end
    end
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign padding      = 1'b0;
`endif

    assign in_ready = ready_en && !bank_full[fill_sel] && !padding;
    assign wr_en    = (in_valid && in_ready) || padding;
    assign wr_word  = padding ? 16'h0000 : in_data;
    assign timeout  = (state == ST_WAIT) && !wr_busy && (timer == BUSY_TO - 16'd1);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[fill_sel][wptr] <= wr_word;
        end
    end

    // Fill and drain never touch the same full flag: the fill bank is the empty one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            wptr      <= '0;
            fill_sel  <= 1'b0;
            drain_sel <= 1'b0;
            bank_full <= '0;
        end else begin
            ready_en <= 1'b1;
            if (wr_en) begin
                wptr <= wptr + AW'(1);
                if (wptr == LAST) begin
                    bank_full[fill_sel] <= 1'b1;
                    fill_sel            <= ~fill_sel;
                end
            end
            if (state == ST_DONE) begin
                bank_full[drain_sel] <= 1'b0;
                drain_sel            <= ~drain_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        wr_start_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bank_full[drain_sel] && sd_init_done && !wr_busy) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                wr_start_en = 1'b1;
                state_nxt   = ST_WAIT;
            end
            ST_WAIT: begin
                if (wr_busy) begin
                    state_nxt = ST_XFER;
                end else if (timeout) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (!wr_busy) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Timer starts at 1 in START so the error becomes visible BUSY_TO cycles after the pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_sec_addr <= START_ADDR;
            wr_data     <= 16'h0000;
            sec_cnt     <= 32'd0;
            error_flag  <= 1'b0;
            rptr        <= '0;
            timer       <= 16'd0;
        end else begin
            case (state)
                ST_START: begin
                    timer <= 16'd1;
                end
                ST_WAIT: begin
                    if (!wr_busy) begin
                        timer <= timer + 16'd1;
                    end
                    if (timeout) begin
                        error_flag <= 1'b1;
                    end
                end
                ST_XFER: begin
                    if (wr_req) begin
                        if (rptr == FULL_CNT) begin
                            error_flag <= 1'b1;
                            wr_data    <= 16'h0000;
                        end else begin
                            wr_data <= mem[drain_sel][rptr[AW-1:0]];
                            rptr    <= rptr + (AW + 1)'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (rptr != FULL_CNT) begin
                        error_flag <= 1'b1;
                    end
                    wr_sec_addr <= wr_sec_addr + 32'd1;
                    sec_cnt     <= sec_cnt + 32'd1;
                    rptr        <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
